// File: rtl/led_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_bank_pkg
// Purpose  : Register addresses and reset defaults shared by the LED bank
//            controller and anything that drives its bus.
// Revision : 1.0 - initial release
// ============================================================================
package led_bank_pkg;

  // Register map on the 2-bit address bus
  localparam logic [1:0] ADDR_ENABLE     = 2'd0;
  localparam logic [1:0] ADDR_BLINK      = 2'd1;
  localparam logic [1:0] ADDR_DUTY       = 2'd2;
  localparam logic [1:0] ADDR_BLINK_HALF = 2'd3;

  // Default blink half-period, in prescaler ticks
  localparam logic [15:0] BLINK_HALF_RST = 16'd500;

endpackage : led_bank_pkg
`default_nettype wire

// File: rtl/led_tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : led_tick_prescaler
// Purpose  : Divides the system clock into a one-cycle tick every PRESC
//            cycles; the tick is high while the counter sits at PRESC-1.
// Revision : 1.0 - initial release
// ============================================================================
module led_tick_prescaler #(
  parameter int PRESC = 50000
) (
  input  logic i_CLK,
  input  logic i_RESET_n,
  output logic o_Tick
);

  localparam int             CNT_W = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(PRESC - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running 0..PRESC-1 counter, wrapping on the tick cycle
  always_ff @(posedge i_CLK) begin
    if (!i_RESET_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign o_Tick = (cnt == LAST);

endmodule : led_tick_prescaler
`default_nettype wire

// File: rtl/led_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_bank_ctrl
// Purpose  : Memory-mapped LED bank: per-LED enable and blink plus a global
//            PWM brightness whose duty only changes on a period boundary.
// Revision : 1.0 - initial release
// ============================================================================
module led_bank_ctrl #(
  parameter int          NUM_LEDS  = 10,
  parameter int          PWM_BITS  = 8,
  parameter int          PRESC     = 50000,
  parameter logic [15:0] BLINK_RST = led_bank_pkg::BLINK_HALF_RST
) (
  input  logic                i_CLK,
  input  logic                i_RESET_n,
  input  logic [1:0]          i_Addr,
  input  logic [15:0]         i_Data,
  input  logic                i_Write_EN,
  output logic [15:0]         o_Data,
  output logic [NUM_LEDS-1:0] o_LED
);

  import led_bank_pkg::*;

  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  logic [NUM_LEDS-1:0] enable;
  logic [NUM_LEDS-1:0] blink;
  logic [PWM_BITS-1:0] duty;
  logic [15:0]         blink_half;
  logic [15:0]         blink_cnt;
  logic                phase;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_act;
  logic                pwm_on;
  logic                tick;
  logic                half_wr;
  logic [15:0]         unused_data;

  // Upper data bits beyond a register's width are deliberately dropped
  assign unused_data = i_Data;
  assign half_wr     = i_Write_EN && (i_Addr == ADDR_BLINK_HALF);

  led_tick_prescaler #(
    .PRESC (PRESC)
  ) u_prescaler (
    .i_CLK     (i_CLK),
    .i_RESET_n (i_RESET_n),
    .o_Tick    (tick)
  );

  // Bus-writable registers; reset beats a coincident write
  always_ff @(posedge i_CLK) begin
    if (!i_RESET_n) begin
      enable     <= '0;
      blink      <= '0;
      duty       <= DUTY_MAX;
      blink_half <= BLINK_RST;
    end else if (i_Write_EN) begin
      case (i_Addr)
        ADDR_ENABLE:     enable     <= i_Data[NUM_LEDS-1:0];
        ADDR_BLINK:      blink      <= i_Data[NUM_LEDS-1:0];
        ADDR_DUTY:       duty       <= i_Data[PWM_BITS-1:0];
        ADDR_BLINK_HALF: blink_half <= i_Data;
        default:         ;
      endcase
    end
  end

  // Blink phase: toggles every BLINK_HALF ticks; a new half-period restarts it
  always_ff @(posedge i_CLK) begin
    if (!i_RESET_n || half_wr || (blink_half == 16'd0)) begin
      blink_cnt <= 16'd0;
      phase     <= 1'b1;
    end else if (tick) begin
      if (blink_cnt == blink_half - 16'd1) begin
        blink_cnt <= 16'd0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 16'd1;
      end
    end
  end

  // PWM counter; the active duty is latched only as the counter wraps
  always_ff @(posedge i_CLK) begin
    if (!i_RESET_n) begin
      pwm_cnt  <= '0;
      duty_act <= DUTY_MAX;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (pwm_cnt == DUTY_MAX) begin
        duty_act <= duty;
      end
    end
  end

  assign pwm_on = (pwm_cnt < duty_act) || (duty_act == DUTY_MAX);

  // Registered LED drive, one cycle behind the internal state
  always_ff @(posedge i_CLK) begin
    if (!i_RESET_n) begin
      o_LED <= '0;
    end else begin
      o_LED <= enable & (~blink | {NUM_LEDS{phase}}) & {NUM_LEDS{pwm_on}};
    end
  end

  // Read mux: written DUTY (not the shadow), zero-extended to 16 bits
  always_comb begin
    o_Data = '0;
    case (i_Addr)
      ADDR_ENABLE:     o_Data[NUM_LEDS-1:0] = enable;
      ADDR_BLINK:      o_Data[NUM_LEDS-1:0] = blink;
      ADDR_DUTY:       o_Data[PWM_BITS-1:0] = duty;
      ADDR_BLINK_HALF: o_Data               = blink_half;
      default:         o_Data               = '0;
    endcase
  end

endmodule : led_bank_ctrl
`default_nettype wire
